// File: rtl/gfifo_step_batcher.sv
// gfifo_step_batcher: batches per-channel step counts from NUM_CH cores into
// flush records for the gfifo transport and polls software for the finish flag.
module gfifo_step_batcher #(
   parameter int unsigned NUM_CH         = 4,
   parameter int unsigned STEP_WIDTH     = 8,
   parameter int unsigned ACC_WIDTH      = 16,
   parameter int unsigned FLUSH_THRESH   = 64,
   parameter int unsigned IDLE_TIMEOUT   = 256,
   parameter int unsigned FETCH_INTERVAL = 5000
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [NUM_CH*STEP_WIDTH-1:0]    step,
   output logic                            stall,
   output logic                            overflow,
   output logic                            flush_valid,
   input  logic                            flush_ready,
   output logic [NUM_CH*ACC_WIDTH-1:0]     flush_count,
   output logic                            flush_last,
   output logic                            poll_req,
   input  logic                            poll_ack,
   input  logic                            poll_result,
   output logic                            done
);

   localparam int unsigned IDLE_W = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int unsigned TMR_W  = (FETCH_INTERVAL > 2) ? $clog2(FETCH_INTERVAL) : 1;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX     = '1;
   localparam logic [ACC_WIDTH-1:0] STALL_LIMIT = ACC_MAX - ACC_WIDTH'((1 << STEP_WIDTH) - 1);
   localparam logic [ACC_WIDTH-1:0] THRESH      = ACC_WIDTH'(FLUSH_THRESH);
   localparam logic [IDLE_W-1:0]    IDLE_LAST   = IDLE_W'(IDLE_TIMEOUT - 1);
   localparam logic [TMR_W-1:0]     TMR_LAST    = TMR_W'(FETCH_INTERVAL - 1);

   typedef enum logic [1:0] {COUNT, REQ, FIN} poll_state_t;

   logic [ACC_WIDTH-1:0] acc      [NUM_CH];
   logic [ACC_WIDTH-1:0] acc_nxt  [NUM_CH];
   logic [ACC_WIDTH-1:0] step_ext [NUM_CH];
   logic [IDLE_W-1:0]    idle_cnt;
   logic [TMR_W-1:0]     timer;
   poll_state_t          state;

   logic accept, any_nz, thresh_hit, idle_hit, trigger, xfer, step_nz, stall_nxt;

   // Trigger evaluation on registered accumulators and next-accumulator values
   always_comb begin
      accept     = !done && !stall;
      any_nz     = 1'b0;
      thresh_hit = 1'b0;
      step_nz    = 1'b0;
      stall_nxt  = 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
         any_nz     = any_nz | (acc[i] != '0);
         thresh_hit = thresh_hit | (acc[i] >= THRESH);
         step_nz    = step_nz | (step[i*STEP_WIDTH +: STEP_WIDTH] != '0);
      end
      idle_hit = (idle_cnt == IDLE_LAST) && any_nz;
      // after done, accumulators never grow, so one transfer empties them for good
      trigger  = thresh_hit || idle_hit || (done && any_nz);
      xfer     = trigger && (!flush_valid || flush_ready);
      for (int i = 0; i < int'(NUM_CH); i++) begin
         step_ext[i] = accept ? ACC_WIDTH'(step[i*STEP_WIDTH +: STEP_WIDTH]) : '0;
         acc_nxt[i]  = xfer ? step_ext[i] : acc[i] + step_ext[i];
         stall_nxt   = stall_nxt | (acc_nxt[i] >= STALL_LIMIT);
      end
   end

   // Accumulators, flush slot, idle timer, stall and overflow
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_CH); i++) acc[i] <= '0;
         stall       <= 1'b0;
         overflow    <= 1'b0;
         flush_valid <= 1'b0;
         flush_last  <= 1'b0;
         flush_count <= '0;
         idle_cnt    <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_CH); i++) acc[i] <= acc_nxt[i];
         stall <= stall_nxt;
         if (stall && !done && step_nz) overflow <= 1'b1;
         if (xfer) begin
            flush_valid <= 1'b1;
            flush_last  <= done;
            for (int i = 0; i < int'(NUM_CH); i++)
               flush_count[i*ACC_WIDTH +: ACC_WIDTH] <= acc[i];
         end else if (flush_ready) begin
            flush_valid <= 1'b0;
            flush_last  <= 1'b0;
         end
         if (xfer || (accept && step_nz)) idle_cnt <= '0;
         else if (idle_cnt != IDLE_LAST)  idle_cnt <= idle_cnt + IDLE_W'(1);
      end
   end

   // Result poll FSM: periodic request, sticky done on a finished result
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= COUNT;
         timer    <= '0;
         poll_req <= 1'b0;
         done     <= 1'b0;
      end else begin
         case (state)
            COUNT: begin
               if (timer == TMR_LAST) begin
                  state    <= REQ;
                  poll_req <= 1'b1;
               end else begin
                  timer <= timer + TMR_W'(1);
               end
            end
            REQ: begin
               if (poll_ack) begin
                  poll_req <= 1'b0;
                  timer    <= '0;
                  if (poll_result) begin
                     done  <= 1'b1;
                     state <= FIN;
                  end else begin
                     state <= COUNT;
                  end
               end
            end
            FIN: begin
               poll_req <= 1'b0;
            end
            default: begin
               state    <= COUNT;
               poll_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gfifo_step_batcher.sv
// Testbench for gfifo_step_batcher: randomized and directed stimulus checked
// against a behavioural model of batching, flush and poll rules.
module tb_gfifo_step_batcher;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] step = '0;
   logic        flush_ready = 1'b0;
   logic        poll_ack = 1'b0;
   logic        poll_result = 1'b0;
   logic        stall, overflow, flush_valid, flush_last, poll_req, done;
   logic [63:0] flush_count;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int m_acc[4];
   int m_cnt[4];
   bit m_stall, m_ovf, m_fv, m_last, m_done, m_preq;
   int m_idle, m_since;

   gfifo_step_batcher dut (
      .clock(clock), .reset(reset), .step(step), .stall(stall), .overflow(overflow),
      .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_count(flush_count),
      .flush_last(flush_last), .poll_req(poll_req), .poll_ack(poll_ack),
      .poll_result(poll_result), .done(done)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [69:0] exp_vec();
      logic [63:0] c;
      for (int i = 0; i < 4; i++) c[i*16 +: 16] = 16'(m_cnt[i]);
      return {m_stall, m_ovf, m_fv, m_last, m_preq, m_done, c};
   endfunction

   function automatic logic [69:0] obs_vec();
      return {stall, overflow, flush_valid, flush_last, poll_req, done, flush_count};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin m_acc[i] = 0; m_cnt[i] = 0; end
      m_stall = 0; m_ovf = 0; m_fv = 0; m_last = 0; m_done = 0; m_preq = 0;
      m_idle = 0; m_since = 0;
   endtask

   // Drive one cycle of inputs, advance the model by one clock, sample after the edge
   task automatic tick(input logic [31:0] st, input logic rdy, input logic ack, input logic res);
      int s[4];
      bit nz, th, trig, xf, snz;
      step = st; flush_ready = rdy; poll_ack = ack; poll_result = res;
      snz = 0; nz = 0; th = 0;
      for (int i = 0; i < 4; i++) begin
         s[i] = (!m_done && !m_stall) ? int'(st[i*8 +: 8]) : 0;
         snz |= (s[i] != 0);
         nz  |= (m_acc[i] != 0);
         th  |= (m_acc[i] >= 64);
      end
      if (m_stall && !m_done && st != 0) m_ovf = 1;
      trig = nz && (th || m_idle == 255 || m_done);
      xf   = trig && (!m_fv || rdy);
      if (xf) begin
         for (int i = 0; i < 4; i++) begin m_cnt[i] = m_acc[i]; m_acc[i] = s[i]; end
         m_fv = 1; m_last = m_done;
      end else begin
         if (rdy) begin m_fv = 0; m_last = 0; end
         for (int i = 0; i < 4; i++) m_acc[i] += s[i];
      end
      m_idle = (xf || snz) ? 0 : ((m_idle < 255) ? m_idle + 1 : 255);
      m_stall = 0;
      for (int i = 0; i < 4; i++) if (m_acc[i] >= 65280) m_stall = 1;
      if (!m_done) begin
         if (m_preq) begin
            if (ack) begin
               m_preq = 0; m_since = 0;
               if (res) m_done = 1;
            end
         end else begin
            m_since++;
            if (m_since == 5000) m_preq = 1;
         end
      end
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      step = '0; flush_ready = 0; poll_ack = 0; poll_result = 0;
      reset = 0;
      #1;
      model_reset();
      @(negedge clock);
      reset = 1;
   endtask

   task automatic test_reset();
      step = '0; flush_ready = 0; poll_ack = 0; poll_result = 0;
      reset = 0;
      #1;
      model_reset();
      checks++;
      if (obs_vec() !== 70'd0) begin
         errors++; $display("FAIL reset_state got %h want 0", obs_vec());
      end
      @(negedge clock);
      reset = 1;
   endtask

   task automatic test_threshold();
      int first = 0;
      logic [63:0] rec = '0;
      do_reset();
      for (int c = 1; c <= 24; c++) begin
         tick(32'd8, 1'b1, 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL threshold cycle %0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (flush_valid && first == 0) begin first = c; rec = flush_count; end
      end
      checks++;
      if (first !== 9) begin errors++; $display("FAIL threshold_latency got %0d want 9", first); end
      checks++;
      if (rec !== 64'd64) begin errors++; $display("FAIL threshold_count got %h want %h", rec, 64'd64); end
   endtask

   task automatic test_idle();
      int first = 0;
      logic [63:0] rec = '0;
      logic        last = 1'b1;
      do_reset();
      for (int c = 1; c <= 280; c++) begin
         tick((c <= 5) ? 32'h0003_0000 : 32'd0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL idle cycle %0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (flush_valid && first == 0) begin first = c; rec = flush_count; last = flush_last; end
      end
      checks++;
      if (first !== 261) begin errors++; $display("FAIL idle_latency got %0d want 261", first); end
      checks++;
      if (rec !== (64'd15 << 32) || last !== 1'b0) begin
         errors++; $display("FAIL idle_record got %h last %b want %h last 0", rec, last, 64'd15 << 32);
      end
   endtask

   task automatic test_stall();
      int st_first = 0, ov_first = 0;
      do_reset();
      for (int c = 1; c <= 262; c++) begin
         tick(32'h0000_FF00, 1'b0, 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL stall cycle %0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (stall && st_first == 0) st_first = c;
         if (overflow && ov_first == 0) ov_first = c;
      end
      checks++;
      if (st_first !== 257 || ov_first !== 258) begin
         errors++; $display("FAIL stall_timing got stall %0d ovf %0d want 257 258", st_first, ov_first);
      end
      checks++;
      if (flush_count !== (64'd255 << 16)) begin
         errors++; $display("FAIL stall_hold got %h want %h", flush_count, 64'd255 << 16);
      end
      for (int c = 1; c <= 40; c++) begin
         tick(32'd0, 1'b1, 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL stall_drain cycle %0d got %h want %h", c, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] st;
      do_reset();
      for (int c = 1; c <= 2000; c++) begin
         st = '0;
         if ((c % 700) < 400)
            for (int i = 0; i < 4; i++)
               if ($urandom_range(0, 3) == 0) st[i*8 +: 8] = 8'($urandom_range(1, 40));
         tick(st, 1'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL random cycle %0d got %h want %h", c, obs_vec(), exp_vec());
         end
      end
   endtask

   task automatic test_poll_final();
      int cnt, recs;
      logic [63:0] rec = '0;
      logic        last = 1'b0;
      logic        prev_v;
      logic [31:0] st;
      do_reset();
      for (int n = 0; n < 3; n++) begin
         cnt = 0;
         while (cnt < 6000 && !poll_req) begin
            tick(32'd0, 1'b1, 1'b0, 1'b0);
            cnt++;
            checks++;
            if (obs_vec() !== exp_vec()) begin
               errors++; $display("FAIL poll_wait %0d cycle %0d got %h want %h", n, cnt, obs_vec(), exp_vec());
            end
         end
         checks++;
         if (cnt !== 5000) begin errors++; $display("FAIL poll_interval %0d got %0d want 5000", n, cnt); end
         if (n == 2) tick(32'h0700_0000, 1'b1, 1'b0, 1'b0);
         tick(32'd0, 1'b1, 1'b1, (n == 2) ? 1'b1 : 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL poll_ack %0d got %h want %h", n, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (done !== 1'b1 || poll_req !== 1'b0) begin
         errors++; $display("FAIL poll_done got done %b req %b want 1 0", done, poll_req);
      end
      recs = 0; prev_v = flush_valid;
      for (int c = 1; c <= 300; c++) begin
         st = $urandom();
         tick(st, 1'b1, 1'($urandom_range(0, 1)), 1'b0);
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL final cycle %0d got %h want %h", c, obs_vec(), exp_vec());
         end
         if (flush_valid && !prev_v) begin recs++; rec = flush_count; last = flush_last; end
         prev_v = flush_valid;
      end
      checks++;
      if (recs !== 1 || rec !== (64'd7 << 48) || last !== 1'b1) begin
         errors++; $display("FAIL final_record got n %0d cnt %h last %b want 1 %h 1", recs, rec, last, 64'd7 << 48);
      end
      checks++;
      if (poll_req !== 1'b0 || overflow !== 1'b0 || done !== 1'b1) begin
         errors++; $display("FAIL final_flags got req %b ovf %b done %b want 0 0 1", poll_req, overflow, done);
      end
   endtask

   task automatic test_mid_reset();
      int cnt = 0;
      do_reset();
      tick(32'd64, 1'b0, 1'b0, 1'b0);
      tick(32'd0, 1'b0, 1'b0, 1'b0);
      while (cnt < 6000 && !poll_req) begin
         tick(32'd0, 1'b0, 1'b0, 1'b0);
         cnt++;
      end
      checks++;
      if (flush_valid !== 1'b1 || poll_req !== 1'b1 || flush_count !== 64'd64) begin
         errors++; $display("FAIL midreset_setup got fv %b req %b cnt %h want 1 1 40", flush_valid, poll_req, flush_count);
      end
      #2;
      reset = 0;
      #1;
      model_reset();
      checks++;
      if (obs_vec() !== 70'd0) begin
         errors++; $display("FAIL midreset_async got %h want 0", obs_vec());
      end
      @(negedge clock);
      reset = 1;
      cnt = 0;
      while (cnt < 6000 && !poll_req) begin
         tick(32'd0, 1'b0, 1'b0, 1'b0);
         cnt++;
         checks++;
         if (obs_vec() !== exp_vec()) begin
            errors++; $display("FAIL midreset_run cycle %0d got %h want %h", cnt, obs_vec(), exp_vec());
         end
      end
      checks++;
      if (cnt !== 5000) begin errors++; $display("FAIL midreset_poll got %0d want 5000", cnt); end
   endtask

   initial begin
      test_reset();
      test_threshold();
      test_idle();
      test_stall();
      test_random();
      test_poll_final();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
